control_unit: RTL and testbench

- Sequencer for YASAC.
- Drives every control strobe of `data_unit` from the current instruction's opcode, the status-bit selector and the status register.
- Implements a fetch/execute FSM with a second memory cycle for loads/stores and a halt state.
- Sits directly upstream of `data_unit`, in the top-level `yasac` beside it.

---
 rtl/control_unit.sv | 146 ++++++++++++++
 tb/tb_control_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: fetch/execute sequencer for YASAC.
// Drives every data_unit strobe from the FSM state, the current opcode,
// the status-bit selector and the status register.
// Loads and stores take one extra memory cycle (MEM2).
// HALT is a sink state that only reset can leave.
module control_unit (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] opcode,
  input  logic [2:0] s,
  input  logic [7:0] status,
  output logic [1:0] op,
  output logic       ipc,
  output logic       clpc,
  output logic       wpc,
  output logic       wir,
  output logic       wreg,
  output logic       inm,
  output logic       wmem,
  output logic       rmem,
  output logic       wmar,
  output logic       wsreg,
  output logic       halted
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM2  = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  // ALU operation encodings seen by data_unit
  localparam logic [1:0] OP_PASS_B = 2'b00;
  localparam logic [1:0] OP_PASS_A = 2'b11;

  state_t r_state;
  state_t w_nextState;

  // Opcode class decode, shared by the EXEC and MEM2 branches
  logic w_isHalt;
  logic w_isAluReg;
  logic w_isAluImm;
  logic w_isLoad;
  logic w_isStore;
  logic w_isMemK;
  logic w_isJmp;
  logic w_isBs;
  logic w_isBc;
  logic w_flag;

  assign w_isHalt   = (opcode == 5'b00001);
  assign w_isAluReg = (opcode[4:2] == 3'b001);
  assign w_isAluImm = (opcode[4:2] == 3'b010);
  assign w_isLoad   = (opcode[4:1] == 4'b1000);
  assign w_isStore  = (opcode[4:1] == 4'b1001);
  // ld and st take their address from the immediate; ldr and str from rB
  assign w_isMemK   = (opcode == 5'b10000) || (opcode == 5'b10010);
  assign w_isJmp    = (opcode == 5'b11000);
  assign w_isBs     = (opcode == 5'b11001);
  assign w_isBc     = (opcode == 5'b11010);
  // Selected status flag used by conditional branches
  assign w_flag     = status[s];

  // State register; reset pulls the sequencer back to INIT at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and strobe decode; every strobe defaults low
  always_comb begin
    w_nextState = r_state;
    op          = OP_PASS_B;
    ipc         = 1'b0;
    clpc        = 1'b0;
    wpc         = 1'b0;
    wir         = 1'b0;
    wreg        = 1'b0;
    inm         = 1'b0;
    wmem        = 1'b0;
    rmem        = 1'b0;
    wmar        = 1'b0;
    wsreg       = 1'b0;
    halted      = 1'b0;

    case (r_state)
      ST_INIT: begin
        clpc        = 1'b1;
        w_nextState = ST_FETCH;
      end

      ST_FETCH: begin
        wir         = 1'b1;
        ipc         = 1'b1;
        w_nextState = ST_EXEC;
      end

      ST_EXEC: begin
        w_nextState = ST_FETCH;
        if (w_isHalt) begin
          w_nextState = ST_HALT;
        end else if (w_isAluReg || w_isAluImm) begin
          op    = opcode[1:0];
          wreg  = 1'b1;
          wsreg = 1'b1;
          inm   = w_isAluImm;
        end else if (w_isLoad || w_isStore) begin
          op          = OP_PASS_B;
          inm         = w_isMemK;
          wmar        = 1'b1;
          w_nextState = ST_MEM2;
        end else if (w_isJmp || w_isBs || w_isBc) begin
          op  = OP_PASS_B;
          inm = 1'b1;
          wpc = w_isJmp | (w_isBs & w_flag) | (w_isBc & ~w_flag);
        end
      end

      ST_MEM2: begin
        w_nextState = ST_FETCH;
        if (w_isLoad) begin
          rmem = 1'b1;
          wreg = 1'b1;
        end else if (w_isStore) begin
          op   = OP_PASS_A;
          wmem = 1'b1;
        end
      end

      ST_HALT: begin
        halted      = 1'b1;
        w_nextState = ST_HALT;
      end

      default: begin
        w_nextState = ST_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: directed instruction steps followed by a
// random instruction stream, compared cycle by cycle against an
// instruction-level model of the expected control words.
module tb_control_unit;

  logic       clk;
  logic       reset_n;
  logic [4:0] opcode;
  logic [2:0] s;
  logic [7:0] status;
  logic [1:0] op;
  logic       ipc, clpc, wpc, wir, wreg, inm, wmem, rmem, wmar, wsreg, halted;

  int checkCount;
  int failCount;

  // Control word bit masks: {op[1:0], ipc, clpc, wpc, wir, wreg, inm, wmem, rmem, wmar, wsreg, halted}
  localparam logic [12:0] M_IPC    = 13'h0400;
  localparam logic [12:0] M_CLPC   = 13'h0200;
  localparam logic [12:0] M_WPC    = 13'h0100;
  localparam logic [12:0] M_WIR    = 13'h0080;
  localparam logic [12:0] M_WREG   = 13'h0040;
  localparam logic [12:0] M_INM    = 13'h0020;
  localparam logic [12:0] M_WMEM   = 13'h0010;
  localparam logic [12:0] M_RMEM   = 13'h0008;
  localparam logic [12:0] M_WMAR   = 13'h0004;
  localparam logic [12:0] M_WSREG  = 13'h0002;
  localparam logic [12:0] M_HALTED = 13'h0001;

  logic [12:0] obsWord;
  assign obsWord = {op, ipc, clpc, wpc, wir, wreg, inm, wmem, rmem, wmar, wsreg, halted};

  control_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .opcode  (opcode),
    .s       (s),
    .status  (status),
    .op      (op),
    .ipc     (ipc),
    .clpc    (clpc),
    .wpc     (wpc),
    .wir     (wir),
    .wreg    (wreg),
    .inm     (inm),
    .wmem    (wmem),
    .rmem    (rmem),
    .wmar    (wmar),
    .wsreg   (wsreg),
    .halted  (halted)
  );

  // 10 time-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [12:0] opField(input logic [1:0] v);
    return {v, 11'b0};
  endfunction

  // Instruction-level model: returns the number of cycles the instruction
  // occupies and the expected control word for each of them
  function automatic int modelInstr(input logic [4:0] opc, input logic [2:0] sel,
                                    input logic [7:0] st,
                                    output logic [12:0] w0, output logic [12:0] w1,
                                    output logic [12:0] w2);
    int n;
    logic flag;
    flag = st[sel];
    w0 = M_IPC | M_WIR;
    w1 = '0;
    w2 = '0;
    n  = 2;
    casez (opc)
      5'b001??: w1 = opField(opc[1:0]) | M_WREG | M_WSREG;
      5'b010??: w1 = opField(opc[1:0]) | M_WREG | M_WSREG | M_INM;
      5'b10000: begin w1 = M_INM | M_WMAR; w2 = M_RMEM | M_WREG; n = 3; end
      5'b10001: begin w1 = M_WMAR;         w2 = M_RMEM | M_WREG; n = 3; end
      5'b10010: begin w1 = M_INM | M_WMAR; w2 = opField(2'b11) | M_WMEM; n = 3; end
      5'b10011: begin w1 = M_WMAR;         w2 = opField(2'b11) | M_WMEM; n = 3; end
      5'b11000: w1 = M_INM | M_WPC;
      5'b11001: w1 = M_INM | (flag ? M_WPC : 13'h0);
      5'b11010: w1 = M_INM | (flag ? 13'h0 : M_WPC);
      default:  w1 = '0;
    endcase
    return n;
  endfunction

  // Compares the full control word against the expected one
  task automatic checkOutput(input string tag, input logic [12:0] expected);
    checkCount++;
    assert (obsWord === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obsWord, expected);
    end
  endtask

  // Structural invariants that must hold on every cycle
  task automatic checkInvariants(input logic [4:0] opc);
    logic aluClass;
    aluClass = (opc[4:2] == 3'b001) || (opc[4:2] == 3'b010);
    checkCount++;
    assert ((ipc & wpc) === 1'b0)
    else begin
      failCount++;
      $error("[TB] FAIL ipc_wpc_exclusive: observed=%b expected=0", ipc & wpc);
    end
    checkCount++;
    assert ((wsreg === 1'b0) || aluClass)
    else begin
      failCount++;
      $error("[TB] FAIL wsreg_only_alu: observed=%b expected=0 opcode=%b", wsreg, opc);
    end
  endtask

  // Drives the instruction inputs and lets the decode settle
  task automatic applyStimulus(input logic [4:0] opc, input logic [2:0] sel, input logic [7:0] st);
    opcode = opc;
    s      = sel;
    status = st;
    #1;
  endtask

  // Reset pulse: INIT must show up asynchronously and last one cycle after release
  task automatic doReset(input string tag);
    reset_n = 1'b0;
    #1;
    checkOutput({tag, "_asserted"}, M_CLPC);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    #1;
    checkOutput({tag, "_init"}, M_CLPC);
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction starting at the beginning of its FETCH cycle
  task automatic runInstr(input string tag, input logic [4:0] opc, input logic [2:0] sel,
                          input logic [7:0] st);
    logic [12:0] w0, w1, w2;
    int n;
    n = modelInstr(opc, sel, st, w0, w1, w2);
    applyStimulus(opc, sel, st);
    checkOutput({tag, "_fetch"}, w0);
    checkInvariants(opc);
    @(posedge clk);
    #1;
    checkOutput({tag, "_exec"}, w1);
    checkInvariants(opc);
    if (n == 3) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "_mem2"}, w2);
      checkInvariants(opc);
    end
    @(posedge clk);
    #1;
  endtask

  // Directed steps, then the halt check, then a random instruction stream
  initial begin
    logic [4:0] rOpc;
    checkCount = 0;
    failCount  = 0;
    reset_n    = 1'b0;
    opcode     = 5'b00000;
    s          = 3'd0;
    status     = 8'h00;
    #2;

    doReset("reset");
    runInstr("nop", 5'b00000, 3'd0, 8'h00);
    runInstr("alu_imm_add", 5'b01001, 3'd0, 8'h00);
    runInstr("alu_reg_sub", 5'b00110, 3'd2, 8'hFF);
    runInstr("ld", 5'b10000, 3'd0, 8'h00);
    runInstr("ldr", 5'b10001, 3'd0, 8'h00);
    runInstr("st", 5'b10010, 3'd0, 8'h00);
    runInstr("str", 5'b10011, 3'd0, 8'h00);
    runInstr("jmp", 5'b11000, 3'd0, 8'h00);
    runInstr("bs_z_set", 5'b11001, 3'd1, 8'h02);
    runInstr("bs_z_clr", 5'b11001, 3'd1, 8'h00);
    runInstr("bc_z_set", 5'b11010, 3'd1, 8'h02);
    runInstr("bc_z_clr", 5'b11010, 3'd1, 8'h00);
    runInstr("undef_nop", 5'b11111, 3'd7, 8'hFF);

    // Reset during EXEC of an ALU instruction aborts its register write
    applyStimulus(5'b00101, 3'd0, 8'h00);
    checkOutput("abort_fetch", M_IPC | M_WIR);
    @(posedge clk);
    #1;
    checkOutput("abort_exec", opField(2'b01) | M_WREG | M_WSREG);
    doReset("abort_reset");
    runInstr("after_abort", 5'b00100, 3'd0, 8'h00);

    // halt: strobes stay low regardless of opcode until reset
    runInstr("halt", 5'b00001, 3'd0, 8'h00);
    for (int i = 0; i < 22; i++) begin
      applyStimulus(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 8'($urandom));
      checkOutput("halted", M_HALTED);
      @(posedge clk);
      #1;
    end
    doReset("halt_reset");

    // Random instruction stream (halt remapped to nop to keep it running)
    for (int i = 0; i < 200; i++) begin
      rOpc = 5'($urandom_range(0, 31));
      if (rOpc == 5'b00001) rOpc = 5'b00000;
      runInstr("random", rOpc, 3'($urandom_range(0, 7)), 8'($urandom));
    end

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
